// File: rtl/fp16_subtractor_seq_if.sv
// Handshake and operand/result bundle for the multi-cycle fp16 subtractor.
// The requester drives start/A/B; the subtractor answers with busy/done/diff.
interface fp16_subtractor_seq_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] diff;

  modport master (
    output start, A, B,
    input  busy, done, diff
  );

  modport slave (
    input  start, A, B,
    output busy, done, diff
  );
endinterface

// File: rtl/fp16_subtractor_seq.sv
// Multi-cycle IEEE-754 half-precision subtractor (diff = A - B), flush-to-zero,
// round to nearest even. Normalisation shifts one bit per cycle.
module fp16_subtractor_seq #(
  parameter int unsigned EXP_BIAS = 15,
  parameter logic [15:0] QNAN     = 16'h7E00
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fp16_subtractor_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, ROUND} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] diff_q, diff_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        special_q, special_d;
  logic [15:0] spec_res_q, spec_res_d;
  logic        sign_q, sign_d;
  logic        eff_sub_q, eff_sub_d;
  logic [5:0]  exp_q, exp_d;
  logic [13:0] ma_q, ma_d;
  logic [13:0] mb_q, mb_d;
  logic [14:0] mant_q, mant_d;

  // Special-operand screening on the raw inputs, used only on the capture edge.
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, b_sign_eff;
  logic        spec_hit;
  logic [15:0] spec_val;

  always_comb begin
    a_nan      = (bus.A[14:10] == 5'h1f) && (bus.A[9:0] != '0);
    b_nan      = (bus.B[14:10] == 5'h1f) && (bus.B[9:0] != '0);
    a_inf      = (bus.A[14:10] == 5'h1f) && (bus.A[9:0] == '0);
    b_inf      = (bus.B[14:10] == 5'h1f) && (bus.B[9:0] == '0);
    a_zero     = (bus.A[14:10] == '0);
    b_zero     = (bus.B[14:10] == '0);
    b_sign_eff = ~bus.B[15];
    spec_hit   = 1'b1;
    spec_val   = '0;
    if (a_nan || b_nan)
      spec_val = QNAN;
    else if (a_inf && b_inf && (bus.A[15] == bus.B[15]))
      spec_val = QNAN;
    else if (a_inf)
      spec_val = bus.A;
    else if (b_inf)
      spec_val = {b_sign_eff, bus.B[14:0]};
    else if (a_zero && b_zero)
      spec_val = (bus.A[15] && b_sign_eff) ? 16'h8000 : 16'h0000;
    else if (a_zero)
      spec_val = {b_sign_eff, bus.B[14:0]};
    else if (b_zero)
      spec_val = bus.A;
    else
      spec_hit = 1'b0;
  end

  // Alignment: larger magnitude first, smaller right-shifted with sticky collection.
  logic        a_ge_b;
  logic [15:0] big_op;
  logic [14:0] small_op;
  logic [4:0]  exp_diff;
  logic [27:0] small_ext;
  logic [13:0] small_sh;

  always_comb begin
    a_ge_b    = a_q[14:0] >= b_q[14:0];
    big_op    = a_ge_b ? a_q : b_q;
    small_op  = a_ge_b ? b_q[14:0] : a_q[14:0];
    exp_diff  = big_op[14:10] - small_op[14:10];
    small_ext = {1'b1, small_op[9:0], 3'b000, 14'h0000} >> exp_diff;
    if (exp_diff >= 5'd13)
      small_sh = 14'd1;
    else
      small_sh = {small_ext[27:15], small_ext[14] | (|small_ext[13:0])};
  end

  // Round to nearest even on {LSB, G, R, S} = mant_q[3:0].
  logic        round_inc;
  logic [11:0] rnd;
  logic [5:0]  exp_r;
  logic [15:0] round_val;

  always_comb begin
    round_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd       = {1'b0, mant_q[13:3]} + {11'd0, round_inc};
    exp_r     = exp_q + {5'd0, rnd[11]};
    if (exp_r >= 6'd31)
      round_val = {sign_q, 5'h1f, 10'h000};
    else
      round_val = {sign_q, exp_r[4:0], rnd[11] ? rnd[10:1] : rnd[9:0]};
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    diff_d     = diff_q;
    a_d        = a_q;
    b_d        = b_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    mant_d     = mant_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d        = bus.A;
          b_d        = {~bus.B[15], bus.B[14:0]};
          special_d  = spec_hit;
          spec_res_d = spec_val;
          busy_d     = 1'b1;
          state_d    = ALIGN;
        end
      end
      ALIGN: begin
        if (special_q) begin
          diff_d  = spec_res_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sign_d    = big_op[15];
          exp_d     = {1'b0, big_op[14:10]};
          ma_d      = {1'b1, big_op[9:0], 3'b000};
          mb_d      = small_sh;
          eff_sub_d = a_q[15] ^ b_q[15];
          state_d   = SUB;
        end
      end
      SUB: begin
        mant_d  = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                            : ({1'b0, ma_q} + {1'b0, mb_q});
        state_d = NORM;
      end
      NORM: begin
        if (mant_q == '0) begin
          diff_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (mant_q[14]) begin
          mant_d  = {1'b0, mant_q[14:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 6'd1;
          state_d = ROUND;
        end else if (!mant_q[13]) begin
          // Another left shift would take the exponent to zero: flush instead.
          if (exp_q == 6'd1) begin
            diff_d  = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            mant_d = {mant_q[13:0], 1'b0};
            exp_d  = exp_q - 6'd1;
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        diff_d  = round_val;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      mant_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      diff_q     <= diff_d;
      a_q        <= a_d;
      b_q        <= b_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      mant_q     <= mant_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;

  a_busy_done_excl: assert property (@(posedge CLK) disable iff (RESET) !(busy_q && done_q));
  a_exp_range:      assert property (@(posedge CLK) disable iff (RESET) exp_q <= 6'(2 * EXP_BIAS + 2));

endmodule

// File: tb/tb_fp16_subtractor_seq.sv
// Scoreboard bench for fp16_subtractor_seq: expected diff and latency are queued at
// issue time (directed constants or an exact-arithmetic model) and checked on done.
module tb_fp16_subtractor_seq;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  fp16_subtractor_seq_if bus ();

  fp16_subtractor_seq #(.EXP_BIAS(15), .QNAN(16'h7E00)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    int unsigned lat;
    int unsigned cap;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    int unsigned lat;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned edge_cnt = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  // Exact reference: operands as scaled integers, exact difference, then RNE to 11 bits.
  function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output int unsigned lat);
    logic   a_nan, b_nan, a_inf, b_inf, az, bz, sa, sb, neg;
    int     ea, eb, emin, emax, p, e_lead, k, sh;
    longint va, vb, s, mag, q, rem, half;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 0);
    az = (a[14:10] == 0);
    bz = (b[14:10] == 0);
    lat = 1;
    if (a_nan || b_nan) begin r = 16'h7E00; return; end
    if (a_inf && b_inf && a[15] == b[15]) begin r = 16'h7E00; return; end
    if (a_inf) begin r = a; return; end
    if (b_inf) begin r = {~b[15], b[14:0]}; return; end
    if (az && bz) begin r = (a[15] && !b[15]) ? 16'h8000 : 16'h0000; return; end
    if (az) begin r = {~b[15], b[14:0]}; return; end
    if (bz) begin r = a; return; end
    sa = a[15];
    sb = ~b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    emin = (ea < eb) ? ea : eb;
    emax = (ea < eb) ? eb : ea;
    va = longint'({1'b1, a[9:0]}) << (ea - emin);
    vb = longint'({1'b1, b[9:0]}) << (eb - emin);
    s = (sa ? -va : va) + (sb ? -vb : vb);
    if (s == 0) begin r = 16'h0000; lat = 3; return; end
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e_lead = emin + p - 10;
    if (e_lead < 1) begin r = 16'h0000; lat = 2 + emax; return; end
    k = emax - e_lead;
    if (k < 0) k = 0;
    lat = 4 + k;
    if (p > 10) begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end else begin
      q = mag << (10 - p);
    end
    if (q == 2048) begin q = 1024; e_lead++; end
    if (e_lead >= 31) r = {neg, 5'h1f, 10'h000};
    else              r = {neg, 5'(e_lead), 10'(q)};
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] d, input int unsigned lat);
    exp_t e;
    e.a = a; e.b = b; e.diff = d; e.lat = lat; e.cap = edge_cnt + 1;
    sb_q.push_back(e);
  endtask

  // One operation: wait for idle, pulse start, then scramble A/B while busy.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input int unsigned lat);
    int unsigned guard = 0;
    @(negedge CLK);
    while (bus.busy && guard < 100) begin @(negedge CLK); guard++; end
    check("issue_idle", bus.busy, 0);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    push_exp(a, b, d, lat);
    @(negedge CLK);
    bus.start = 1'b0; bus.A = 16'($urandom); bus.B = 16'($urandom);
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin @(negedge CLK); guard++; end
    check("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic gen_pair(input bit near, output logic [15:0] a, output logic [15:0] b);
    int e;
    a = 16'($urandom);
    b = 16'($urandom);
    if (near) begin
      if ($urandom_range(0, 7) == 0) a[14:10] = 5'($urandom_range(1, 3));
      e = int'(a[14:10]) + int'($urandom_range(0, 4)) - 2;
      if (e < 1) e = 1;
      if (e > 30) e = 30;
      b[14:10] = 5'(e);
      if ($urandom_range(0, 3) == 0) b[9:0] = a[9:0] ^ 10'($urandom_range(0, 7));
    end
  endtask

  // start held high: a new pair is presented whenever the DUT is idle (incl. done cycles).
  task automatic stream(input int unsigned n, input bit near);
    int unsigned sent = 0, guard = 0, lat;
    logic [15:0] a, b, d;
    while (sent < n && guard < n * 40) begin
      @(negedge CLK);
      guard++;
      if (!bus.busy) begin
        gen_pair(near, a, b);
        ref_sub(a, b, d, lat);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        push_exp(a, b, d, lat);
        sent++;
      end else begin
        bus.A = 16'($urandom); bus.B = 16'($urandom);
      end
    end
    @(negedge CLK);
    bus.start = 1'b0;
    check("stream_sent", sent, n);
  endtask

  always @(negedge CLK) begin
    if (!RESET && bus.done) begin
      check("busy_with_done", bus.busy, 0);
      if (sb_q.size() == 0) begin
        check("spurious_done", bus.done, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("diff %h-%h", mon_e.a, mon_e.b), bus.diff, mon_e.diff);
        check($sformatf("latency %h-%h", mon_e.a, mon_e.b), edge_cnt - mon_e.cap, mon_e.lat);
      end
    end
  end

  vec_t dirs [17] = '{
    '{16'h4000, 16'h3C00, 16'h3C00, 5},
    '{16'h3C00, 16'hC000, 16'h4200, 4},
    '{16'h3C00, 16'h3BFF, 16'h1000, 15},
    '{16'h3C00, 16'h3C00, 16'h0000, 3},
    '{16'h7C00, 16'h7C00, 16'h7E00, 1},
    '{16'h7E01, 16'h3C00, 16'h7E00, 1},
    '{16'h3C00, 16'hFC00, 16'h7C00, 1},
    '{16'h7BFF, 16'hFBFF, 16'h7C00, 4},
    '{16'h3C00, 16'h0001, 16'h3C00, 1},
    '{16'h3C00, 16'h1401, 16'h3BFE, 5},
    '{16'h8000, 16'h0000, 16'h8000, 1},
    '{16'h0000, 16'h0000, 16'h0000, 1},
    '{16'h0800, 16'h0600, 16'h0000, 4},
    '{16'h3C00, 16'hBC00, 16'h4000, 4},
    '{16'hC000, 16'hC000, 16'h0000, 3},
    '{16'hFC00, 16'hFC00, 16'h7E00, 1},
    '{16'h0000, 16'h3C00, 16'hBC00, 1}
  };

  initial begin
    bus.start = 1'b1; bus.A = 16'h4000; bus.B = 16'h3C00;
    repeat (3) @(negedge CLK);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 16'h0000);
    bus.start = 1'b0;
    RESET = 1'b0;

    foreach (dirs[i]) begin
      issue(dirs[i].a, dirs[i].b, dirs[i].d, dirs[i].lat);
      drain();
    end

    // Abort a long normalisation; the pending result must never appear.
    issue(16'h3C00, 16'h3BFF, 16'h1000, 15);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_diff", bus.diff, 16'h0000);
    sb_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    check("abort_idle", bus.busy, 0);

    stream(500, 1'b0);
    drain();
    stream(1500, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
